// File: rtl/led_pattern_engine_pkg.sv
// Shared types for the LED pattern engine: pattern mode codes and scan direction.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_BIN   = 2'b00,
        MODE_SCAN  = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_GRAY  = 2'b11
    } led_mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } scan_dir_t;

endpackage

// File: rtl/led_pattern_engine_if.sv
// Control/status bundle between a controller and the LED pattern engine.
interface led_pattern_engine_if
    import led_pkg::*;
#(
    parameter int NUM_LEDS = 6,
    parameter int PWM_BITS = 4
);
    led_mode_t             mode;
    logic                  pause;
    logic                  step_req;
    logic [PWM_BITS-1:0]   brightness;
    logic                  step_tick;
    logic [NUM_LEDS-1:0]   LED;

    modport master (
        output mode, pause, step_req, brightness,
        input  step_tick, LED
    );

    modport slave (
        input  mode, pause, step_req, brightness,
        output step_tick, LED
    );
endinterface

// File: rtl/led_pattern_engine_tick_prescaler.sv
// Clock-enable generator: one-cycle tick every CLK_HZ/STEP_HZ clocks, freezable and clearable.
module tick_prescaler #(
    parameter int CLK_HZ  = 27_000_000,
    parameter int STEP_HZ = 4
) (
    input  logic CLOCK_27,
    input  logic RST,
    input  logic clr,
    input  logic hold,
    output logic tick
);
    localparam int DIV   = CLK_HZ / STEP_HZ;
    localparam int CNT_W = $clog2(DIV);

    logic [CNT_W-1:0] cnt_q;

    // Tick is asserted for the whole terminal count, so a held prescaler keeps it high.
    assign tick = (cnt_q == CNT_W'(DIV - 1));

    always_ff @(posedge CLOCK_27) begin
        if (RST || clr) begin
            cnt_q <= '0;
        end else if (!hold) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/led_pattern_engine.sv
// Status/heartbeat LED driver: four step patterns, global PWM dimming, pause and single-step.
module led_pattern_engine
    import led_pkg::*;
#(
    parameter int CLK_HZ   = 27_000_000,
    parameter int STEP_HZ  = 4,
    parameter int NUM_LEDS = 6,
    parameter int PWM_BITS = 4
) (
    input  logic CLOCK_27,
    input  logic RST,
    led_pattern_engine_if.slave bus
);
    localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [NUM_LEDS-1:0] ALL_ON = {NUM_LEDS{1'b1}};

    led_mode_t             mode_q;
    logic [NUM_LEDS-1:0]   bin_cnt_q, bin_cnt_d;
    logic [NUM_LEDS-1:0]   pattern_q, pattern_d;
    logic [NUM_LEDS-1:0]   led_q;
    logic [POS_W-1:0]      scan_pos_q, scan_pos_d;
    scan_dir_t             scan_dir_q, scan_dir_d;
    logic [PWM_BITS-1:0]   pwm_cnt_q;
    logic                  step_tick_q;
    logic                  tick, mode_chg, adv, pwm_on;

    tick_prescaler #(
        .CLK_HZ  (CLK_HZ),
        .STEP_HZ (STEP_HZ)
    ) u_prescaler (
        .CLOCK_27 (CLOCK_27),
        .RST      (RST),
        .clr      (mode_chg),
        .hold     (bus.pause),
        .tick     (tick)
    );

    assign mode_chg  = (bus.mode != mode_q);
    assign adv       = (tick & ~bus.pause) | (bus.step_req & bus.pause);
    assign pwm_on    = (bus.brightness == {PWM_BITS{1'b1}}) || (pwm_cnt_q < bus.brightness);
    assign bin_cnt_d = bin_cnt_q + NUM_LEDS'(1);

    // Bounce scan: each end position is visited once before turning around.
    generate
        if (NUM_LEDS > 1) begin : g_scan
            always_comb begin
                scan_pos_d = scan_pos_q;
                scan_dir_d = scan_dir_q;
                if (scan_dir_q == DIR_UP) begin
                    if (scan_pos_q == POS_W'(NUM_LEDS - 1)) begin
                        scan_dir_d = DIR_DOWN;
                        scan_pos_d = POS_W'(NUM_LEDS - 2);
                    end else begin
                        scan_pos_d = scan_pos_q + 1'b1;
                    end
                end else begin
                    if (scan_pos_q == '0) begin
                        scan_dir_d = DIR_UP;
                        scan_pos_d = POS_W'(1);
                    end else begin
                        scan_pos_d = scan_pos_q - 1'b1;
                    end
                end
            end
        end else begin : g_scan_single
            assign scan_pos_d = '0;
            assign scan_dir_d = DIR_UP;
        end
    endgenerate

    always_comb begin
        pattern_d = pattern_q;
        case (mode_q)
            MODE_BIN:   pattern_d = bin_cnt_d;
            MODE_GRAY:  pattern_d = bin_cnt_d ^ (bin_cnt_d >> 1);
            MODE_SCAN:  pattern_d = NUM_LEDS'(1) << scan_pos_d;
            MODE_BLINK: pattern_d = (pattern_q == '0) ? ALL_ON : '0;
            default:    pattern_d = pattern_q;
        endcase
    end

    always_ff @(posedge CLOCK_27) begin
        if (RST) begin
            mode_q      <= bus.mode;
            bin_cnt_q   <= '0;
            scan_pos_q  <= '0;
            scan_dir_q  <= DIR_UP;
            pattern_q   <= '0;
            pwm_cnt_q   <= '0;
            step_tick_q <= 1'b0;
            led_q       <= ALL_ON;
        end else begin
            pwm_cnt_q   <= pwm_cnt_q + 1'b1;
            led_q       <= ~(pattern_q & {NUM_LEDS{pwm_on}});
            step_tick_q <= adv & ~mode_chg;
            // A mode switch restarts the new pattern from its first frame and swallows any step.
            if (mode_chg) begin
                mode_q     <= bus.mode;
                bin_cnt_q  <= '0;
                scan_pos_q <= '0;
                scan_dir_q <= DIR_UP;
                pattern_q  <= (bus.mode == MODE_SCAN) ? NUM_LEDS'(1) : '0;
            end else if (adv) begin
                pattern_q <= pattern_d;
                case (mode_q)
                    MODE_BIN, MODE_GRAY: bin_cnt_q <= bin_cnt_d;
                    MODE_SCAN: begin
                        scan_pos_q <= scan_pos_d;
                        scan_dir_q <= scan_dir_d;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.step_tick = step_tick_q;
    assign bus.LED       = led_q;
endmodule

// File: tb/tb_led_pattern_engine.sv
// Bench for led_pattern_engine: table vectors, corner-case sequences and a random run against a step-count model.
module tb_led_pattern_engine;
    import led_pkg::*;

    localparam int CLK_HZ   = 40;
    localparam int STEP_HZ  = 4;
    localparam int DIV      = CLK_HZ / STEP_HZ;
    localparam int NUM_LEDS = 6;
    localparam int PWM_BITS = 4;
    localparam int LED_MASK = (1 << NUM_LEDS) - 1;
    localparam int PWM_MAX  = (1 << PWM_BITS) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    led_pattern_engine_if #(.NUM_LEDS(NUM_LEDS), .PWM_BITS(PWM_BITS)) bus ();

    led_pattern_engine #(
        .CLK_HZ   (CLK_HZ),
        .STEP_HZ  (STEP_HZ),
        .NUM_LEDS (NUM_LEDS),
        .PWM_BITS (PWM_BITS)
    ) dut (
        .CLOCK_27 (clk),
        .RST      (rst),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int tick_cnt = 0;

    // Model state: prescaler phase, steps taken since the pattern (re)started, PWM phase.
    int m_presc, m_n, m_pwm, m_mode;
    bit m_blank;
    int exp_led;
    bit exp_tick;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pat_of(input int mode, input int n, input bit blank);
        int p, g, period;
        if (blank) return 0;
        case (mode)
            0: return n % (1 << NUM_LEDS);
            1: begin
                if (NUM_LEDS == 1) return 1;
                period = 2 * (NUM_LEDS - 1);
                p = n % period;
                if (p > NUM_LEDS - 1) p = period - p;
                return 1 << p;
            end
            2: return (n % 2 == 1) ? LED_MASK : 0;
            default: begin
                g = n % (1 << NUM_LEDS);
                return g ^ (g >> 1);
            end
        endcase
    endfunction

    // Advance the model by one edge using the inputs now applied, clock, then compare.
    task automatic cycle();
        int pat;
        bit on, chg, tk, adv;
        if (rst) begin
            m_presc = 0; m_n = 0; m_pwm = 0; m_blank = 1;
            m_mode = int'(bus.mode);
            exp_led = LED_MASK; exp_tick = 0;
        end else begin
            pat = pat_of(m_mode, m_n, m_blank);
            on  = (int'(bus.brightness) == PWM_MAX) || (m_pwm < int'(bus.brightness));
            exp_led = on ? (~pat & LED_MASK) : LED_MASK;
            m_pwm = (m_pwm + 1) % (PWM_MAX + 1);
            chg = (int'(bus.mode) != m_mode);
            tk  = (m_presc == DIV - 1);
            adv = (tk && !bus.pause) || (bus.step_req && bus.pause);
            exp_tick = adv && !chg;
            if (chg) begin
                m_mode = int'(bus.mode); m_n = 0; m_presc = 0; m_blank = 0;
            end else begin
                if (adv) begin m_n++; m_blank = 0; end
                if (!bus.pause) m_presc = tk ? 0 : m_presc + 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("step_tick", {31'd0, bus.step_tick}, {31'd0, exp_tick});
        check("LED", 32'(bus.LED), 32'(exp_led));
        if (bus.step_tick) tick_cnt++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) cycle();
        rst = 1'b0;
    endtask

    task automatic pulse_step();
        bus.step_req = 1'b1;
        cycle();
        bus.step_req = 1'b0;
        cycle();
    endtask

    task automatic wait_tick(input int limit, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!bus.step_tick && n < limit);
    endtask

    typedef struct {
        led_mode_t   mode;
        logic        pause;
        logic [3:0]  bright;
        int          ncyc;
        int          exp_ticks;
        logic [5:0]  exp_led;
    } vec_t;

    vec_t vecs[12];
    int   scan_exp[11];

    initial begin
        int t0, n, lit, on_cnt;
        logic [5:0] led_ref;
        logic [3:0] br_list[3];
        int         on_exp[3];

        vecs[0]  = '{MODE_BIN,   1'b0, 4'd15, 35,  3, 6'h3C};
        vecs[1]  = '{MODE_GRAY,  1'b0, 4'd15, 45,  4, 6'h39};
        vecs[2]  = '{MODE_SCAN,  1'b0, 4'd15, 25,  2, 6'h3B};
        vecs[3]  = '{MODE_SCAN,  1'b0, 4'd15, 75,  7, 6'h37};
        vecs[4]  = '{MODE_BLINK, 1'b0, 4'd15, 15,  1, 6'h00};
        vecs[5]  = '{MODE_BLINK, 1'b0, 4'd15, 25,  2, 6'h3F};
        vecs[6]  = '{MODE_BIN,   1'b1, 4'd15, 50,  0, 6'h3F};
        vecs[7]  = '{MODE_SCAN,  1'b0, 4'd15, 5,   0, 6'h3F};
        vecs[8]  = '{MODE_SCAN,  1'b0, 4'd15, 105, 10, 6'h3E};
        vecs[9]  = '{MODE_BIN,   1'b0, 4'd0,  35,  3, 6'h3F};
        vecs[10] = '{MODE_BLINK, 1'b0, 4'd4,  15,  1, 6'h3F};
        vecs[11] = '{MODE_BLINK, 1'b0, 4'd4,  17,  1, 6'h00};
        scan_exp = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};
        br_list  = '{4'd0, 4'd4, 4'd15};
        on_exp   = '{0, 4, 16};

        rst = 1'b1;
        bus.mode = MODE_BIN; bus.pause = 1'b0; bus.step_req = 1'b0; bus.brightness = 4'd15;

        // Table vectors, each from a fresh reset.
        for (int i = 0; i < 12; i++) begin
            bus.mode = vecs[i].mode; bus.pause = vecs[i].pause;
            bus.brightness = vecs[i].bright; bus.step_req = 1'b0;
            do_reset(2);
            check($sformatf("vec%0d reset LED", i), 32'(bus.LED), 32'h3F);
            t0 = tick_cnt;
            for (int c = 0; c < vecs[i].ncyc; c++) cycle();
            check($sformatf("vec%0d ticks", i), 32'(tick_cnt - t0), 32'(vecs[i].exp_ticks));
            check($sformatf("vec%0d LED", i), 32'(bus.LED), 32'(vecs[i].exp_led));
            $display("vec %0d mode %0d pause %0d bright %0d cycles %0d -> ticks %0d LED %h",
                     i, vecs[i].mode, vecs[i].pause, vecs[i].bright, vecs[i].ncyc, tick_cnt - t0, bus.LED);
        end

        // Binary wrap at 63 -> 0 via single steps.
        bus.mode = MODE_BIN; bus.pause = 1'b1; bus.brightness = 4'd15;
        do_reset(2);
        for (int i = 0; i < 63; i++) pulse_step();
        check("wrap LED at 63", 32'(bus.LED), 32'h00);
        pulse_step();
        check("wrap LED at 0", 32'(bus.LED), 32'h3F);
        $display("seq wrap: LED %h after 64 steps", bus.LED);

        // Pause freezes everything; single steps only while paused.
        bus.pause = 1'b0;
        do_reset(2);
        for (int c = 0; c < 15; c++) cycle();
        check("pause start LED", 32'(bus.LED), 32'h3E);
        bus.pause = 1'b1;
        t0 = tick_cnt; n = 0;
        for (int c = 0; c < 100; c++) begin
            cycle();
            if (bus.LED !== 6'h3E) n++;
        end
        check("pause ticks", 32'(tick_cnt - t0), 32'd0);
        check("pause LED changes", 32'(n), 32'd0);
        t0 = tick_cnt;
        for (int i = 0; i < 3; i++) pulse_step();
        check("step ticks", 32'(tick_cnt - t0), 32'd3);
        check("step LED", 32'(bus.LED), 32'h3B);
        bus.pause = 1'b0; bus.step_req = 1'b1;
        t0 = tick_cnt;
        for (int c = 0; c < 10; c++) cycle();
        bus.step_req = 1'b0;
        check("unpaused step_req ticks", 32'(tick_cnt - t0), 32'd1);
        check("unpaused step_req LED", 32'(bus.LED), 32'h3A);
        $display("seq pause/step: LED %h", bus.LED);

        // Mode change landing on the tick cycle.
        bus.mode = MODE_BIN; bus.brightness = 4'd15;
        do_reset(2);
        for (int c = 0; c < 9; c++) cycle();
        bus.mode = MODE_GRAY;
        cycle();
        check("modechg step_tick", {31'd0, bus.step_tick}, 32'd0);
        wait_tick(30, n);
        check("modechg next tick delay", 32'(n), 32'd10);
        cycle();
        check("modechg gray 1 LED", 32'(bus.LED), 32'h3E);
        $display("seq mode change: next tick after %0d cycles, LED %h", n, bus.LED);

        // Scan lit-index sequence.
        bus.mode = MODE_SCAN;
        do_reset(2);
        for (int i = 0; i < 11; i++) begin
            wait_tick(30, n);
            cycle();
            lit = -1;
            for (int b = 0; b < NUM_LEDS; b++) if (bus.LED[b] == 1'b0) lit = b;
            check($sformatf("scan index %0d", i), 32'(lit), 32'(scan_exp[i]));
        end
        $display("seq scan: 11 positions checked");

        // PWM duty in blink-on phase.
        bus.mode = MODE_BLINK; bus.pause = 1'b1; bus.brightness = 4'd15;
        do_reset(2);
        pulse_step();
        for (int k = 0; k < 3; k++) begin
            bus.brightness = br_list[k];
            cycle(); cycle();
            on_cnt = 0;
            for (int c = 0; c < 16; c++) begin
                cycle();
                if (bus.LED == 6'h00) on_cnt++;
            end
            check($sformatf("pwm bright %0d on cycles", br_list[k]), 32'(on_cnt), 32'(on_exp[k]));
            $display("seq pwm: brightness %0d lit %0d of 16", br_list[k], on_cnt);
        end

        // One-cycle reset in the middle of a scan.
        bus.mode = MODE_SCAN; bus.pause = 1'b0; bus.brightness = 4'd15;
        do_reset(2);
        for (int c = 0; c < 35; c++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("midreset LED", 32'(bus.LED), 32'h3F);
        check("midreset step_tick", {31'd0, bus.step_tick}, 32'd0);
        wait_tick(30, n);
        check("midreset first tick", 32'(n), 32'(DIV));
        $display("seq mid-scan reset: first tick after %0d cycles", n);

        // Random run checked cycle by cycle against the model.
        led_ref = 6'h00;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) == 0) bus.mode = led_mode_t'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) bus.pause = ~bus.pause;
            bus.step_req = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 199) == 0) bus.brightness = 4'($urandom_range(0, 15));
            cycle();
            led_ref = led_ref | bus.LED;
        end
        rst = 1'b0;
        $display("random run: 3000 cycles, final LED %h", bus.LED);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
